// File: rtl/counter_2bit.sv
// Free-running modulo-2^WIDTH up-counter with terminal-count and wrap pulse.
// Define COUNTER_2BIT_GRAY_EN to present the count on `counter` in Gray code.
module counter_2bit #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             clear,
   output logic [WIDTH-1:0] counter,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;

   logic [WIDTH-1:0] bin_q, bin_d;
   logic             wrap_q, wrap_d;
   logic             at_max;

   always_comb begin
      at_max = (bin_q == MAX_VAL);
      bin_d  = bin_q + WIDTH'(1);
      wrap_d = at_max;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         bin_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         wrap_q <= wrap_d;
      end
   end

`ifdef COUNTER_2BIT_GRAY_EN
   // Gray value is registered from the next binary count so it changes with bin_q.
   logic [WIDTH-1:0] gray_q, gray_d;

   always_comb begin
      gray_d = bin_d ^ (bin_d >> 1);
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) gray_q <= '0;
      else        gray_q <= gray_d;
   end

   assign counter = gray_q;
`else
   assign counter = bin_q;
`endif

   assign tc   = at_max;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_2bit.sv
// Directed + randomized bench for counter_2bit (WIDTH=2 and WIDTH=1 instances)
// against an arithmetic model of the count sequence.
module tb_counter_2bit;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic [1:0] counter2;
   logic       tc2, wrap2;
   logic [0:0] counter1;
   logic       tc1, wrap1;

   int asserts = 0;
   int fails   = 0;

   // model: number of increments since last clear, plus expected wrap flags
   int n = 0;
   bit w2 = 0, w1 = 0;
   int wraps_seen;

   counter_2bit #(.WIDTH(2)) dut2 (.clk(clk), .clear(clear), .counter(counter2), .tc(tc2), .wrap(wrap2));
   counter_2bit #(.WIDTH(1)) dut1 (.clk(clk), .clear(clear), .counter(counter1), .tc(tc1), .wrap(wrap1));

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input int b);
`ifdef COUNTER_2BIT_GRAY_EN
      return 32'(b ^ (b >> 1));
`else
      return 32'(b);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      w2 = (n % 4 == 3);
      w1 = (n % 2 == 1);
      n++;
   endtask

   task automatic model_clear();
      n = 0; w2 = 0; w1 = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " cnt2"},  32'(counter2), enc(n % 4));
      chk({tag, " tc2"},   32'(tc2),      32'(n % 4 == 3));
      chk({tag, " wrap2"}, 32'(wrap2),    32'(w2));
      chk({tag, " cnt1"},  32'(counter1), enc(n % 2));
      chk({tag, " tc1"},   32'(tc1),      32'(n % 2 == 1));
      chk({tag, " wrap1"}, 32'(wrap1),    32'(w1));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      // reset-then-run: clear low at t=10, released at t=17
      #10 clear = 1'b0;
      #1 model_clear();
      check_all("reset");
      #5 check_all("reset hold");           // t=16, after the t=15 edge
      #1 clear = 1'b1;                      // t=17
      tick("run1"); tick("run2"); tick("run3"); tick("run4");
      chk("run4 literal wrap", 32'(wrap2), 32'd1);

      // free-run 8 edges from 0, count wrap pulses
      wraps_seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick("free");
         if (wrap2) wraps_seen++;
      end
      chk("wrap pulse count", 32'(wraps_seen), 32'd2);

      // clear mid-count at counter=2
      tick("pre mid"); tick("pre mid");
      #3 clear = 1'b0;
      #1 model_clear();
      check_all("mid clear");
      #1 clear = 1'b1;
      tick("after mid");

      // clear during wrap pulse
      tick("to wrap"); tick("to wrap"); tick("to wrap");
      chk("wrap before clear", 32'(wrap2), 32'd1);
      #2 clear = 1'b0;
      #1 model_clear();
      check_all("clear in wrap");
      #1 clear = 1'b1;

      // clear coincident with the edge that would wrap
      tick("to max"); tick("to max"); tick("to max");
      @(posedge clk);
      clear = 1'b0;
      model_clear();
      #1 check_all("coincident clear");
      #2 clear = 1'b1;

      // randomized run with occasional clear pulses
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            #2 clear = 1'b0;
            #1 model_clear();
            check_all("rnd clear");
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1 check_all("rnd clear hold");
            end
            clear = 1'b1;
         end
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
